// File: rtl/conv_pool_engine.sv
// Streaming 3x3 valid-padding convolution with shift/ReLU/saturation and an
// optional 2x2 stride-2 max pool. It consumes one raster-order frame per start.
module conv_pool_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  relu_en_i,
  input  logic                  pool_en_i,
  input  logic [4:0]            shift_i,
  input  logic                  wgt_we_i,
  input  logic [3:0]            wgt_addr_i,
  input  logic [DATA_WIDTH-1:0] wgt_data_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int PW   = (IMG_W - 2) / 2;
  localparam int PH   = (IMG_H - 2) / 2;
  localparam int PW_N = (PW > 0) ? PW : 1;
  localparam int PIW  = (PW_N > 1) ? $clog2(PW_N) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] wgt_q [9];
  logic [DATA_WIDTH-1:0]        line1_q [IMG_W];
  logic [DATA_WIDTH-1:0]        line2_q [IMG_W];
  logic [DATA_WIDTH-1:0]        win_q [3][2];
  logic signed [OUT_WIDTH-1:0]  pbuf_q [PW_N];
  logic signed [OUT_WIDTH-1:0]  hmax_q;
  logic [CW-1:0]                col_q;
  logic [RW-1:0]                row_q;
  logic                         relu_q, pool_q;
  logic [4:0]                   shift_q;

  logic                         out_valid_q, out_last_q;
  logic [OUT_WIDTH-1:0]         out_data_q;

  logic                         out_free, pix_xfer, start_acc, last_pix;
  logic [DATA_WIDTH-1:0]        new_col [3];
  logic [DATA_WIDTH-1:0]        win_pix [3][3];
  logic signed [ACC_WIDTH-1:0]  acc, w_ext, p_ext, shifted;
  logic signed [OUT_WIDTH-1:0]  res, pair_max, pool_val, out_sel;
  logic                         win_ok, emit, is_last;
  logic [CW-2:0]                col_half;
  logic [PIW-1:0]               pidx;

  // Valid/ready: a beat moves on a rising edge where valid and ready are both
  // high; a producer holding valid keeps its data stable until that edge, and
  // a pixel is only consumed when the output register can take its result.
  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == S_RUN) && out_free;
  assign pix_xfer   = in_valid_i && in_ready_o;
  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign last_pix   = pix_xfer && (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign state_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)  state_d = S_RUN;
      S_RUN:   if (last_pix) state_d = S_DRAIN;
      S_DRAIN: if (out_free) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window columns c-2, c-1 come from registers; column c is the incoming
  // pixel stacked under the two line-buffer entries for this column.
  always_comb begin
    new_col[0] = line2_q[col_q];
    new_col[1] = line1_q[col_q];
    new_col[2] = in_data_i;
    for (int i = 0; i < 3; i++) begin
      win_pix[i][0] = win_q[i][0];
      win_pix[i][1] = win_q[i][1];
      win_pix[i][2] = new_col[i];
    end
  end

  always_comb begin
    acc   = '0;
    w_ext = '0;
    p_ext = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_ext = {{(ACC_WIDTH-DATA_WIDTH){wgt_q[3*i+j][DATA_WIDTH-1]}}, wgt_q[3*i+j]};
        p_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, win_pix[i][j]};
        acc   = acc + w_ext * p_ext;
      end
    end
  end

  always_comb begin
    shifted = acc >>> shift_q;
    if (relu_q && shifted[ACC_WIDTH-1]) shifted = '0;
    if (shifted > SAT_MAX)      res = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[OUT_WIDTH-1:0];
    else                        res = shifted[OUT_WIDTH-1:0];
  end

  // Conv row/col parity equals pixel row/col parity since both are offset by 2.
  always_comb begin
    win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    col_half = col_q[CW-1:1];
    pidx     = PIW'(col_half - (CW-1)'(1));
    pair_max = (hmax_q > res) ? hmax_q : res;
    pool_val = (pbuf_q[pidx] > pair_max) ? pbuf_q[pidx] : pair_max;
    emit     = win_ok && (!pool_q || (row_q[0] && col_q[0]));
    out_sel  = pool_q ? pool_val : res;
    if (pool_q)
      is_last = (row_q == RW'(2*PH + 1)) && (col_q == CW'(2*PW + 1));
    else
      is_last = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) wgt_q[k] <= '0;
    end else if ((state_q == S_IDLE) && wgt_we_i && (wgt_addr_i <= 4'd8)) begin
      wgt_q[wgt_addr_i] <= wgt_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      relu_q  <= 1'b0;
      pool_q  <= 1'b0;
      shift_q <= '0;
    end else if (start_acc) begin
      relu_q  <= relu_en_i;
      pool_q  <= pool_en_i;
      shift_q <= shift_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      col_q  <= '0;
      row_q  <= '0;
      hmax_q <= '0;
      for (int c = 0; c < IMG_W; c++) begin
        line1_q[c] <= '0;
        line2_q[c] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= '0;
        win_q[i][1] <= '0;
      end
      for (int p = 0; p < PW_N; p++) pbuf_q[p] <= '0;
    end else if (pix_xfer) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
      line2_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= in_data_i;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= new_col[i];
      end
      // Even conv col opens a horizontal pair; odd col closes it, and on an
      // even conv row the pair max waits in the pool buffer for the next row.
      if (win_ok && pool_q) begin
        if (!col_q[0])     hmax_q       <= res;
        else if (!row_q[0]) pbuf_q[pidx] <= pair_max;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (pix_xfer && emit) begin
      out_valid_q <= 1'b1;
      out_last_q  <= is_last;
      out_data_q  <= out_sel;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine on a 4x4 image: directed frames plus randomized
// frames, scored against an arithmetic model of convolution and pooling.
module tb_conv_pool_engine;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int AW = 32;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, relu_en, pool_en;
  logic [4:0]    shift;
  logic          wgt_we;
  logic [3:0]    wgt_addr;
  logic [DW-1:0] wgt_data;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid, out_last, out_ready;
  logic [OW-1:0] out_data;
  logic          busy, done;
  logic [1:0]    state;

  conv_pool_engine #(
    .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .relu_en_i(relu_en),
    .pool_en_i(pool_en), .shift_i(shift), .wgt_we_i(wgt_we),
    .wgt_addr_i(wgt_addr), .wgt_data_i(wgt_data), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .state_o(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model
  int            w_m [9];
  int            img [IH*IW];
  logic [OW-1:0] exp_q [$];

  function automatic int post_proc(int acc, int sh, bit relu_m);
    int v;
    v = acc >>> sh;
    if (relu_m && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic void build_expected(bit relu_m, bit pool_m, int sh);
    int cv [IH-2][IW-2];
    int acc, v, m;
    for (int r = 0; r < IH-2; r++)
      for (int c = 0; c < IW-2; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += w_m[3*i+j] * img[(r+i)*IW + c + j];
        cv[r][c] = post_proc(acc, sh, relu_m);
      end
    if (!pool_m) begin
      for (int r = 0; r < IH-2; r++)
        for (int c = 0; c < IW-2; c++) begin
          v = cv[r][c];
          exp_q.push_back(v[OW-1:0]);
        end
    end else begin
      for (int pr = 0; pr < (IH-2)/2; pr++)
        for (int pc = 0; pc < (IW-2)/2; pc++) begin
          m = cv[2*pr][2*pc];
          if (cv[2*pr][2*pc+1] > m)   m = cv[2*pr][2*pc+1];
          if (cv[2*pr+1][2*pc] > m)   m = cv[2*pr+1][2*pc];
          if (cv[2*pr+1][2*pc+1] > m) m = cv[2*pr+1][2*pc+1];
          exp_q.push_back(m[OW-1:0]);
        end
    end
  endfunction

  // scoreboard / monitor
  logic [OW-1:0] e;
  logic          stall_prev = 1'b0;
  logic [OW:0]   stall_snap = '0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data_last", {out_last, out_data}, stall_snap);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", out_last, exp_q.size() == 0);
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      stall_prev <= out_valid && !out_ready;
      stall_snap <= {out_last, out_data};
    end
  end

  // driver tasks
  task automatic write_wgt(input int a, input int v);
    wgt_we   = 1'b1;
    wgt_addr = a[3:0];
    wgt_data = v[DW-1:0];
    @(posedge clk); #1;
    wgt_we   = 1'b0;
  endtask

  task automatic program_weights();
    for (int k = 0; k < 9; k++) write_wgt(k, w_m[k]);
  endtask

  task automatic fill_img(input int mode, input int v);
    for (int k = 0; k < IH*IW; k++) img[k] = (mode == 0) ? $urandom_range(0, 255) : v;
  endtask

  task automatic run_frame(input bit relu_m, input bit pool_m, input int sh,
                           input int rmode, input bit intrude);
    int base;
    logic [DW-1:0] tmp;
    build_expected(relu_m, pool_m, sh);
    relu_en = relu_m; pool_en = pool_m; shift = sh[4:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_run", busy, 1);
    check("state_run", state, 1);
    @(posedge clk); #1;
    base = done_cnt;
    fork
      begin
        int k, guard;
        bit xfer, intruded;
        k = 0; guard = 0; intruded = 0;
        while (k < IH*IW && guard < 2000) begin
          in_valid = (rmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
          in_data  = img[k][DW-1:0];
          if (intrude && k == 5 && !intruded) begin
            intruded = 1;
            start = 1'b1; pool_en = !pool_m; relu_en = !relu_m; shift = 5'd3;
            tmp = w_m[4][DW-1:0];
            wgt_we = 1'b1; wgt_addr = 4'd4; wgt_data = ~tmp;
          end
          @(negedge clk);
          xfer = in_valid && in_ready;
          @(posedge clk); #1;
          start = 1'b0; wgt_we = 1'b0;
          relu_en = relu_m; pool_en = pool_m; shift = sh[4:0];
          if (xfer) k++;
          guard++;
        end
        in_valid = 1'b0;
        check("pixel_timeout", guard < 2000, 1);
      end
      begin
        int cyc, stall_cnt;
        bit stall_used;
        cyc = 0; stall_cnt = 0; stall_used = 0;
        while (done_cnt == base && cyc < 3000) begin
          if (rmode == 1) begin
            if (!stall_used && out_valid) begin
              stall_used = 1;
              stall_cnt  = 5;
            end
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
          end else if (rmode == 2) begin
            out_ready = ($urandom_range(0, 2) != 0);
          end else begin
            out_ready = 1'b1;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
        check("frame_timeout", cyc < 3000, 1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("done_pulses", done_cnt - base, 1);
    check("results_left", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // main sequence
  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; pool_en = 1'b0; shift = '0;
    wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) w_m[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // weights cleared by reset
    fill_img(0, 0);
    run_frame(0, 0, 0, 0, 0);

    // all-ones window
    for (int k = 0; k < 9; k++) w_m[k] = 1;
    program_weights();
    fill_img(1, 1);
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0);

    // saturation and shift
    for (int k = 0; k < 9; k++) w_m[k] = 127;
    program_weights();
    fill_img(1, 255);
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 16, 0, 0);

    // negative results with and without relu
    for (int k = 0; k < 9; k++) w_m[k] = -1;
    program_weights();
    fill_img(1, 1);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0);

    // back-pressure stall mid-frame, random data
    for (int k = 0; k < 9; k++) w_m[k] = int'($urandom_range(0, 255)) - 128;
    program_weights();
    write_wgt(9, 77);
    write_wgt(15, 33);
    fill_img(0, 0);
    run_frame(0, 0, 6, 1, 0);
    fill_img(0, 0);
    run_frame(1, 1, 5, 1, 0);

    // reset in the middle of a frame aborts it and clears the weights
    fill_img(0, 0);
    start = 1'b1; relu_en = 1'b0; pool_en = 1'b0; shift = '0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data = img[k][DW-1:0];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_state", state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 9; k++) w_m[k] = 0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_ready", in_ready, 0);
      check("abort_no_out", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    fill_img(0, 0);
    run_frame(0, 0, 0, 0, 0);

    // start and weight write while running are ignored
    for (int k = 0; k < 9; k++) w_m[k] = int'($urandom_range(0, 255)) - 128;
    program_weights();
    fill_img(0, 0);
    run_frame(0, 0, 7, 0, 1);
    fill_img(0, 0);
    run_frame(0, 1, 7, 2, 0);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 9; k++) w_m[k] = int'($urandom_range(0, 255)) - 128;
      program_weights();
      fill_img(0, 0);
      run_frame($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(3, 12), 2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
